sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 The module SHALL have parameter GAP_CYCLES, default 2, giving the number of idle cycles inserted between repetitions (legal range 0..15).
REQ-002 Port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port start, input, 1 bit: transmit request, honoured only when busy=0.
REQ-005 Port pattern, input, 8 bits: bit pattern, sampled on an accepted start.
REQ-006 Port len, input, 4 bits: pattern length in bits, sampled on an accepted start; 1..8 as given, 0 or 9..15 SHALL be treated as 8.
REQ-007 Port reps, input, 4 bits: repetition count, sampled on an accepted start; the pattern SHALL be sent reps+1 times (1..16).
REQ-008 Port dout, output, 1 bit: serial data bit.
REQ-009 Port dout_valid, output, 1 bit: dout carries a pattern bit this cycle.
REQ-010 Port busy, output, 1 bit: a transmission is in progress.
REQ-011 Port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-012 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-013 The FSM SHALL have the states IDLE, SEND, GAP and DONE.
REQ-014 In IDLE, start=1 SHALL latch pattern, effective length L and reps, and move to SEND; busy, dout_valid and the first bit SHALL appear in the cycle after the accepting edge (latency 1).
REQ-015 SEND SHALL emit the pattern MSB-first within its field: bit L-1 first, down to bit 0, one bit per cycle, with dout_valid=1.
REQ-016 The bits of pattern above L-1 SHALL be ignored.
REQ-017 After bit 0 with repetitions remaining, SEND SHALL enter GAP for GAP_CYCLES cycles, or go directly to bit L-1 of the next repetition when GAP_CYCLES=0, so there is no idle cycle between repetitions.
REQ-018 In GAP, dout_valid=0, dout=0 and busy=1.
REQ-019 After bit 0 of the final repetition, SEND SHALL enter DONE for exactly one cycle with done=1, busy=1, dout_valid=0 and dout=0, and then return to IDLE.
REQ-020 The total busy duration SHALL be (reps+1)*L + reps*GAP_CYCLES + 1 cycles.
REQ-021 start asserted while busy=1 (including the DONE cycle) SHALL be ignored, and SHALL NOT be queued.
REQ-022 Changes on pattern, len or reps while busy=1 SHALL NOT affect the transmission in progress.
REQ-023 start held high continuously SHALL cause back-to-back transmissions, each accepted in the first IDLE cycle after DONE, so there is one IDLE cycle between done and the next first bit.
REQ-024 The bit counter and repetition counter SHALL NOT wrap: reps=15 SHALL yield exactly 16 repetitions, and len=8 SHALL yield exactly 8 bits.
REQ-025 In IDLE, dout=0, dout_valid=0, busy=0 and done=0.

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE and clear the latched pattern and all counters.
REQ-027 After a reset edge, the outputs SHALL be dout=0, dout_valid=0, busy=0 and done=0.
REQ-028 rst SHALL take priority over start in the same cycle: no transmission is accepted.
REQ-029 Reset mid-transmission SHALL abort the transmission immediately, with no done pulse, and the next start after rst deasserts SHALL behave as from power-up.

Verification
REQ-030 Basic transmission: pattern=8'd21, len=8, reps=0, start for 1 cycle -> dout 0,0,0,1,0,1,0,1 with dout_valid=1 for 8 cycles, then done=1 for 1 cycle, busy high for 9 cycles.
REQ-031 Short pattern: pattern=8'hF5, len=3, reps=1, GAP_CYCLES=2 -> 1,0,1, then 2 invalid cycles, then 1,0,1, then done; busy for 9 cycles.
REQ-032 Length clamping and no gap: len=0 and len=12, each with GAP_CYCLES=0 and reps=2 -> 24 contiguous valid bits (the 8-bit pattern sent 3 times), then done.
REQ-033 Ignore while busy: a start pulse in mid-SEND with a different pattern -> output unchanged, no second transmission; start held high -> done, 1 IDLE cycle, first bit of the next transmission.
REQ-034 Reset mid-transmission: rst asserted at bit 4 of pattern 8'd21 -> all outputs 0 on the next cycle, no done; start with rst=1 ignored.
REQ-035 Maximum repetitions: reps=15, len=1, pattern=1, GAP_CYCLES=0 -> exactly 16 valid '1' bits, then done.

Source files
------------

// File: rtl/sequence_generator_if.sv
// Request/serial-output bundle for sequence_generator; master drives the request, slave returns the bit stream.
interface sequence_generator_if;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       dout;
  logic       dout_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, pattern, len, reps,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serialises an up-to-8-bit pattern MSB-first, reps+1 times with GAP_CYCLES idle cycles between repetitions.
// Latency 1 cycle from accepted start to first bit; start is dropped (not queued) while busy.
module sequence_generator #(
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_generator_if.slave  sif
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [3:0] GAP_M1 = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t     state_q, state_nxt;
  logic [7:0] pat_q, pat_nxt;
  logic [2:0] lm1_q, lm1_nxt;
  logic [2:0] bit_q, bit_nxt;
  logic [3:0] rep_q, rep_nxt;
  logic [3:0] gap_q, gap_nxt;
  logic [3:0] len_eff;
  logic       dout_d, vld_d, busy_d, done_d;

  assign len_eff = (sif.len == 4'd0 || sif.len > 4'd8) ? 4'd8 : sif.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pat_q          <= '0;
      lm1_q          <= '0;
      bit_q          <= '0;
      rep_q          <= '0;
      gap_q          <= '0;
      sif.dout       <= 1'b0;
      sif.dout_valid <= 1'b0;
      sif.busy       <= 1'b0;
      sif.done       <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      pat_q          <= pat_nxt;
      lm1_q          <= lm1_nxt;
      bit_q          <= bit_nxt;
      rep_q          <= rep_nxt;
      gap_q          <= gap_nxt;
      sif.dout       <= dout_d;
      sif.dout_valid <= vld_d;
      sif.busy       <= busy_d;
      sif.done       <= done_d;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pat_nxt   = pat_q;
    lm1_nxt   = lm1_q;
    bit_nxt   = bit_q;
    rep_nxt   = rep_q;
    gap_nxt   = gap_q;
    case (state_q)
      IDLE: begin
        if (sif.start) begin
          pat_nxt   = sif.pattern;
          lm1_nxt   = 3'(len_eff - 4'd1);
          bit_nxt   = 3'(len_eff - 4'd1);
          rep_nxt   = sif.reps;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (bit_q != 3'd0) begin
          bit_nxt = bit_q - 3'd1;
        end else if (rep_q == 4'd0) begin
          state_nxt = DONE;
        end else begin
          rep_nxt = rep_q - 4'd1;
          // With no gap the next repetition starts on the very next cycle.
          if (GAP_CYCLES == 0) begin
            bit_nxt = lm1_q;
          end else begin
            gap_nxt   = GAP_M1;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          bit_nxt   = lm1_q;
          state_nxt = SEND;
        end else begin
          gap_nxt = gap_q - 4'd1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so they line up with the state.
  always_comb begin
    dout_d = 1'b0;
    vld_d  = 1'b0;
    busy_d = (state_nxt != IDLE);
    done_d = (state_nxt == DONE);
    if (state_nxt == SEND) begin
      dout_d = pat_nxt[bit_nxt];
      vld_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Drives a GAP_CYCLES=2 and a GAP_CYCLES=0 instance with the same stimulus and checks both every cycle.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;

  int ncmp = 0;
  int nfail = 0;
  bit armed = 0;

  sequence_generator_if if0 ();
  sequence_generator_if if2 ();

  assign if0.start = start;  assign if0.pattern = pattern;
  assign if0.len   = len;    assign if0.reps    = reps;
  assign if2.start = start;  assign if2.pattern = pattern;
  assign if2.len   = len;    assign if2.reps    = reps;

  sequence_generator #(.GAP_CYCLES(0)) u0 (.clk(clk), .rst(rst), .sif(if0));
  sequence_generator #(.GAP_CYCLES(2)) u2 (.clk(clk), .rst(rst), .sif(if2));

  always #5 clk = ~clk;

  // Reference: output of cycle k (1 = first cycle after accept) from plain arithmetic. {busy,vld,dout,done}
  function automatic logic [3:0] ref_out(int k, logic [7:0] p, int l, int r, int g);
    int total = (r + 1) * l + r * g;
    int pos;
    if (k <= total) begin
      pos = (k - 1) % (l + g);
      if (pos < l) return {1'b1, 1'b1, p[l - 1 - pos], 1'b0};
      return 4'b1000;
    end
    if (k == total + 1) return 4'b1001;
    return 4'b0000;
  endfunction

  bit         act[2];
  int         kc[2];
  logic [7:0] mp[2];
  int         ml[2], mr[2];
  logic [3:0] expv[2];

  always @(posedge clk) begin
    armed = 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d]  = 0;
        expv[d] = 4'b0000;
      end else if (act[d]) begin
        kc[d]++;
        expv[d] = ref_out(kc[d], mp[d], ml[d], mr[d], d * 2);
        if (expv[d] == 4'b0000) act[d] = 0;
      end else if (start) begin
        act[d]  = 1;
        kc[d]   = 1;
        mp[d]   = pattern;
        ml[d]   = (len == 0 || len > 8) ? 8 : int'(len);
        mr[d]   = int'(reps);
        expv[d] = ref_out(1, mp[d], ml[d], mr[d], d * 2);
      end else begin
        expv[d] = 4'b0000;
      end
    end
  end

  task automatic chkv(input string nm, input logic [3:0] got, input logic [3:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, want);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    ncmp++;
    if (got != want) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Per-instance activity accumulators for the literal checks; index 0 = no gap, 1 = gap of 2.
  int          bcnt[2], vcnt[2], dcnt[2];
  logic [31:0] vbits[2];

  always @(negedge clk) begin
    if (armed) begin
      chkv("cycle_gap0", {if0.busy, if0.dout_valid, if0.dout, if0.done}, expv[0]);
      chkv("cycle_gap2", {if2.busy, if2.dout_valid, if2.dout, if2.done}, expv[1]);
      if (if0.busy) bcnt[0]++;
      if (if2.busy) bcnt[1]++;
      if (if0.done) dcnt[0]++;
      if (if2.done) dcnt[1]++;
      if (if0.dout_valid) begin vcnt[0]++; vbits[0] = {vbits[0][30:0], if0.dout}; end
      if (if2.dout_valid) begin vcnt[1]++; vbits[1] = {vbits[1][30:0], if2.dout}; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_acc();
    for (int d = 0; d < 2; d++) begin
      bcnt[d] = 0; vcnt[d] = 0; dcnt[d] = 0; vbits[d] = '0;
    end
  endtask

  task automatic run_one(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input int waitn);
    clear_acc();
    pattern = p; len = l; reps = r; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (waitn) tick();
  endtask

  logic [23:0] exp24;

  initial begin
    clear_acc();
    // Reset with start asserted: nothing may be accepted.
    rst = 1'b1; start = 1'b1; pattern = 8'hFF; len = 4'd8; reps = 4'd3;
    repeat (3) tick();
    start = 1'b0; rst = 1'b0;
    chkv("reset_gap0", {if0.busy, if0.dout_valid, if0.dout, if0.done}, 4'b0000);
    chkv("reset_gap2", {if2.busy, if2.dout_valid, if2.dout, if2.done}, 4'b0000);
    tick();

    run_one(8'd21, 4'd8, 4'd0, 12);
    chk("basic_bits", int'(vbits[1][7:0]), 8'b0001_0101);
    chk("basic_vcnt", vcnt[1], 8);
    chk("basic_busy", bcnt[1], 9);
    chk("basic_done", dcnt[1], 1);

    run_one(8'hF5, 4'd3, 4'd1, 14);
    chk("short_bits", int'(vbits[1][5:0]), 6'b101101);
    chk("short_busy_gap2", bcnt[1], 9);
    chk("short_busy_gap0", bcnt[0], 7);

    exp24 = {3{8'hA5}};
    run_one(8'hA5, 4'd0, 4'd2, 30);
    chk("len0_bits", int'(vbits[0][23:0]), int'(exp24));
    chk("len0_busy", bcnt[0], 25);
    run_one(8'hA5, 4'd12, 4'd2, 30);
    chk("len12_bits", int'(vbits[0][23:0]), int'(exp24));
    chk("len12_vcnt", vcnt[0], 24);
    chk("len12_done", dcnt[0], 1);

    // Mid-transmission start with another pattern is dropped.
    clear_acc();
    pattern = 8'd21; len = 4'd8; reps = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    pattern = 8'hFF; len = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    repeat (12) tick();
    chk("ignore_bits", int'(vbits[1][7:0]), 8'b0001_0101);
    chk("ignore_done", dcnt[1], 1);
    chk("ignore_busy", bcnt[1], 9);

    // start held: two transmissions in 20 edges, one idle cycle between them.
    clear_acc();
    pattern = 8'd21; len = 4'd8; reps = 4'd0; start = 1'b1;
    repeat (20) tick();
    start = 1'b0;
    repeat (12) tick();
    chk("held_done", dcnt[1], 2);
    chk("held_busy", bcnt[1], 18);

    // Reset while bit 4 is on the line.
    clear_acc();
    pattern = 8'd21; len = 4'd8; reps = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    repeat (3) tick();
    rst = 1'b1; start = 1'b1;
    repeat (2) tick();
    rst = 1'b0; start = 1'b0;
    repeat (12) tick();
    chk("abort_done", dcnt[1], 0);
    chk("abort_vcnt", vcnt[1], 4);

    run_one(8'h01, 4'd1, 4'd15, 60);
    chk("maxreps_vcnt", vcnt[0], 16);
    chk("maxreps_bits", int'(vbits[0][15:0]), 16'hFFFF);
    chk("maxreps_busy_gap0", bcnt[0], 17);
    chk("maxreps_busy_gap2", bcnt[1], 47);

    // Random traffic, including input churn while busy and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      pattern = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      reps    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      rst     = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (200) tick();

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
